hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Pipeline-control counterpart to the forwarding mux: decides when forwarding cannot resolve a hazard.
//  Detects load-use hazards and holds the pipeline for multi-cycle DIV/MUL in EX.
//  Generates PC/IF_ID/ID_EX stalls and IF_ID/ID_EX/EX_MEM flushes (bubbles).
//  Emits one-cycle div_ready/mul_ready pulses that tell the forwarding logic to select divres/mulres from EX_MEM.
// PARAMETERS
//  DIV_CYCLES  32                           total EX-occupancy cycles of a divide (>=2)
//  MUL_CYCLES  4                            total EX-occupancy cycles of a multiply (>=2)
//  CNT_W       $clog2(DIV_CYCLES)           latency counter width (must also cover MUL_CYCLES)
// PORTS
//  clk            in   1  core clock
//  Rst            in   1  asynchronous, active-low reset
//  IF_ID_rs1      in   5  rs1 of instruction in ID
//  IF_ID_rs2      in   5  rs2 of instruction in ID
//  ID_EX_rd       in   5  rd of instruction in EX
//  ID_EX_memread  in   1  EX instruction is a load
//  ID_EX_div      in   1  EX instruction is DIV/REM
//  ID_EX_mul      in   1  EX instruction is MUL*
//  branch_taken   in   1  branch/jump resolved taken in EX
//  PC_stall       out  1  hold PC
//  IF_ID_stall    out  1  hold IF_ID register
//  ID_EX_stall    out  1  hold ID_EX register
//  IF_ID_flush    out  1  zero IF_ID (bubble)
//  ID_EX_flush    out  1  zero ID_EX (bubble)
//  EX_MEM_flush   out  1  zero EX_MEM (bubble)
//  div_ready      out  1  divide result valid in EX_MEM this cycle
//  mul_ready      out  1  multiply result valid in EX_MEM this cycle
//  busy           out  1  FSM in DIV_BUSY or MUL_BUSY
// BEHAVIOUR
//  Reset (Rst low, async): state=IDLE, cnt=0. Every output reads 0 while Rst is low.
//  FSM states: IDLE, DIV_BUSY, MUL_BUSY, DIV_DONE, MUL_DONE.
//  start_div = ID_EX_div in IDLE/DIV_DONE/MUL_DONE.
//  start_mul = ID_EX_mul & !ID_EX_div in the same states. DIV wins if both are set.
//  On start:
//   - next state is xx_BUSY; cnt <= xx_CYCLES-2.
//   - Stall is asserted combinationally in the start cycle.
//  xx_BUSY:
//   - cnt!=0: stall, cnt <= cnt-1.
//   - cnt==0: no stall; next state is xx_DONE (the instruction leaves EX at this edge).
//  xx_DONE lasts one cycle; div_ready/mul_ready=1 only in DIV_DONE/MUL_DONE.
//   - Next state is IDLE, or a new BUSY if a start occurs (back-to-back allowed; ready and new stall coexist).
//  Net effect per op: xx_CYCLES EX cycles, xx_CYCLES-1 stall cycles, ready exactly 1 cycle after release.
//  ex_hold (start or BUSY with cnt!=0):
//   - PC_stall = IF_ID_stall = ID_EX_stall = EX_MEM_flush = 1; other flushes 0.
//  load_use = ID_EX_memread & ID_EX_rd!=0 & (ID_EX_rd==IF_ID_rs1 | ID_EX_rd==IF_ID_rs2):
//   - PC_stall = IF_ID_stall = ID_EX_flush = 1 for one cycle.
//   - Clears by itself once the load advances.
//  branch_taken: IF_ID_flush = ID_EX_flush = 1; PC_stall = IF_ID_stall = 0.
//  Priority: ex_hold > branch_taken > load_use.
//   - branch_taken with ID_EX_div/mul is illegal decode; ex_hold wins.
//   - branch_taken with load_use: flush only, no stall.
//  Reset mid-op: state returns to IDLE immediately; no ready pulse is emitted for the aborted op.
//  All outputs are combinational from state/cnt/inputs; no output latency beyond the FSM register.
// STRUCTURE
//  hazard_pkg holds:
//   - typedef enum logic [2:0] hz_state_t {IDLE,DIV_BUSY,MUL_BUSY,DIV_DONE,MUL_DONE}
//   - localparams DIV_CYCLES_DEF=32, MUL_CYCLES_DEF=4
//  Sub-module latency_counter (load/decrement/zero flag, CNT_W bits) is shared by the DIV and MUL paths.
//  The FSM and output decode stay in this module.
// TESTING
//  1. Load-use: memread=1, ID_EX_rd=5, IF_ID_rs2=5 -> PC_stall=IF_ID_stall=ID_EX_flush=1 for 1 cycle.
//     Repeat with ID_EX_rd=0 -> all outputs 0.
//  2. DIV_CYCLES=32, ID_EX_div held in EX -> PC_stall/ID_EX_stall/EX_MEM_flush high 31 cycles.
//     Then 1 release cycle; div_ready=1 on cycle 33 only.
//  3. MUL_CYCLES=4, two MULs back-to-back -> stalls 3 cycles, release cycle.
//     mul_ready=1 and a new stall in the same cycle; second ready pulse 4 cycles later.
//  4. branch_taken=1 with load_use true -> IF_ID_flush=ID_EX_flush=1, PC_stall=0.
//  5. Rst low on cycle 10 of a DIV -> all outputs 0, busy=0.
//     After Rst release with ID_EX_div=0: div_ready never pulses.
//  6. ID_EX_div=ID_EX_mul=1 -> 31 stall cycles and div_ready, mul_ready stays 0.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and default latencies for the hazard/stall control block.
package hazard_pkg;

   // Control FSM states: a BUSY state per long-latency unit, then a one-cycle DONE.
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DIV_BUSY = 3'd1,
      MUL_BUSY = 3'd2,
      DIV_DONE = 3'd3,
      MUL_DONE = 3'd4
   } hz_state_t;

   localparam int DIV_CYCLES_DEF = 32;
   localparam int MUL_CYCLES_DEF = 4;

   // True while a multi-cycle op is still occupying EX.
   function automatic logic is_busy(input hz_state_t s);
      return (s == DIV_BUSY) || (s == MUL_BUSY);
   endfunction

   // States in which a new DIV/MUL may be accepted into EX.
   function automatic logic can_start(input hz_state_t s);
      return (s == IDLE) || (s == DIV_DONE) || (s == MUL_DONE);
   endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline <-> hazard unit bundle: register-address/decode info in, stall/flush/ready out.
interface hazard_stall_unit_if;
   logic [4:0] IF_ID_rs1;
   logic [4:0] IF_ID_rs2;
   logic [4:0] ID_EX_rd;
   logic       ID_EX_memread;
   logic       ID_EX_div;
   logic       ID_EX_mul;
   logic       branch_taken;
   logic       PC_stall;
   logic       IF_ID_stall;
   logic       ID_EX_stall;
   logic       IF_ID_flush;
   logic       ID_EX_flush;
   logic       EX_MEM_flush;
   logic       div_ready;
   logic       mul_ready;
   logic       busy;

   // Pipeline side: supplies hazard information, consumes control.
   modport master (
      output IF_ID_rs1, IF_ID_rs2, ID_EX_rd, ID_EX_memread, ID_EX_div, ID_EX_mul, branch_taken,
      input  PC_stall, IF_ID_stall, ID_EX_stall, IF_ID_flush, ID_EX_flush, EX_MEM_flush,
             div_ready, mul_ready, busy
   );

   // Hazard unit side.
   modport slave (
      input  IF_ID_rs1, IF_ID_rs2, ID_EX_rd, ID_EX_memread, ID_EX_div, ID_EX_mul, branch_taken,
      output PC_stall, IF_ID_stall, ID_EX_stall, IF_ID_flush, ID_EX_flush, EX_MEM_flush,
             div_ready, mul_ready, busy
   );
endinterface

// File: rtl/hazard_stall_unit_latency_counter.sv
// Down-counter shared by the DIV and MUL paths: load on start, decrement while
// the op is still occupying EX, zero flag marks the release cycle.
module latency_counter #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             Rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   // Load takes precedence; decrement saturates at zero.
   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard/stall control: load-use detection, multi-cycle DIV/MUL hold in EX,
// branch flushes, and one-cycle result-ready pulses for the forwarding logic.
module hazard_stall_unit
   import hazard_pkg::*;
#(
   parameter int DIV_CYCLES = DIV_CYCLES_DEF,
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
   input  logic                clk,
   input  logic                Rst,
   hazard_stall_unit_if.slave  hz
);

   hz_state_t        r_state;
   logic [CNT_W-1:0] w_cnt;
   logic             w_cnt_zero;
   logic             w_start_div;
   logic             w_start_mul;
   logic             w_busy;
   logic             w_ex_hold;
   logic             w_load_use;
   logic [CNT_W-1:0] w_cnt_load_val;

   logic w_pc_stall, w_if_id_stall, w_id_ex_stall;
   logic w_if_id_flush, w_id_ex_flush, w_ex_mem_flush;

   // DIV wins when decode flags both units.
   assign w_start_div    = can_start(r_state) && hz.ID_EX_div;
   assign w_start_mul    = can_start(r_state) && hz.ID_EX_mul && !hz.ID_EX_div;
   assign w_busy         = is_busy(r_state);
   // The start cycle itself already holds; the cnt==0 BUSY cycle is the release.
   assign w_ex_hold      = w_start_div || w_start_mul || (w_busy && !w_cnt_zero);
   assign w_load_use     = hz.ID_EX_memread && (hz.ID_EX_rd != 5'd0) &&
                           ((hz.ID_EX_rd == hz.IF_ID_rs1) || (hz.ID_EX_rd == hz.IF_ID_rs2));
   // Start cycle counts as one EX cycle and release as another, hence CYCLES-2.
   assign w_cnt_load_val = w_start_div ? CNT_W'(DIV_CYCLES - 2) : CNT_W'(MUL_CYCLES - 2);

   latency_counter #(
      .CNT_W (CNT_W)
   ) u_latency_counter (
      .clk        (clk),
      .Rst        (Rst),
      .i_load     (w_start_div || w_start_mul),
      .i_load_val (w_cnt_load_val),
      .i_dec      (w_busy && !w_cnt_zero),
      .o_cnt      (w_cnt),
      .o_zero     (w_cnt_zero)
   );

   // Occupancy FSM; a DONE state may chain straight into a new BUSY.
   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE, DIV_DONE, MUL_DONE: begin
               if (w_start_div)      r_state <= DIV_BUSY;
               else if (w_start_mul) r_state <= MUL_BUSY;
               else                  r_state <= IDLE;
            end
            DIV_BUSY: if (w_cnt_zero) r_state <= DIV_DONE;
            MUL_BUSY: if (w_cnt_zero) r_state <= MUL_DONE;
            default:  r_state <= IDLE;
         endcase
      end
   end

   // Stall/flush decode, priority EX hold > taken branch > load-use.
   always_comb begin
      w_pc_stall     = 1'b0;
      w_if_id_stall  = 1'b0;
      w_id_ex_stall  = 1'b0;
      w_if_id_flush  = 1'b0;
      w_id_ex_flush  = 1'b0;
      w_ex_mem_flush = 1'b0;
      if (w_ex_hold) begin
         w_pc_stall     = 1'b1;
         w_if_id_stall  = 1'b1;
         w_id_ex_stall  = 1'b1;
         w_ex_mem_flush = 1'b1;
      end else if (hz.branch_taken) begin
         w_if_id_flush  = 1'b1;
         w_id_ex_flush  = 1'b1;
      end else if (w_load_use) begin
         w_pc_stall     = 1'b1;
         w_if_id_stall  = 1'b1;
         w_id_ex_flush  = 1'b1;
      end
   end

   // Outputs are forced low while reset is asserted, even with live inputs.
   assign hz.PC_stall     = Rst && w_pc_stall;
   assign hz.IF_ID_stall  = Rst && w_if_id_stall;
   assign hz.ID_EX_stall  = Rst && w_id_ex_stall;
   assign hz.IF_ID_flush  = Rst && w_if_id_flush;
   assign hz.ID_EX_flush  = Rst && w_id_ex_flush;
   assign hz.EX_MEM_flush = Rst && w_ex_mem_flush;
   assign hz.div_ready    = Rst && (r_state == DIV_DONE);
   assign hz.mul_ready    = Rst && (r_state == MUL_DONE);
   assign hz.busy         = Rst && w_busy;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit; one line per checked cycle on mismatch.
module tb_hazard_stall_unit;
   import hazard_pkg::*;

   localparam int DIVC = DIV_CYCLES_DEF;   // 32
   localparam int MULC = MUL_CYCLES_DEF;   // 4

   // Output vector order: PC_stall IF_ID_stall ID_EX_stall IF_ID_flush ID_EX_flush EX_MEM_flush div_ready mul_ready busy
   localparam logic [8:0] O_NONE   = 9'b000000000;
   localparam logic [8:0] O_HOLD0  = 9'b111001000;  // start cycle (state not yet BUSY)
   localparam logic [8:0] O_HOLD   = 9'b111001001;  // BUSY, cnt != 0
   localparam logic [8:0] O_REL    = 9'b000000001;  // BUSY, cnt == 0
   localparam logic [8:0] O_DR     = 9'b000000100;
   localparam logic [8:0] O_MR     = 9'b000000010;
   localparam logic [8:0] O_MR_ST  = 9'b111001010;  // MUL_DONE with a new MUL starting
   localparam logic [8:0] O_LU     = 9'b110010000;
   localparam logic [8:0] O_BR     = 9'b000110000;

   logic clk = 1'b0;
   logic Rst;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   hazard_stall_unit_if bus ();

   hazard_stall_unit #(
      .DIV_CYCLES (DIVC),
      .MUL_CYCLES (MULC)
   ) dut (
      .clk (clk),
      .Rst (Rst),
      .hz  (bus)
   );

   function automatic logic [8:0] outs();
      return {bus.PC_stall, bus.IF_ID_stall, bus.ID_EX_stall, bus.IF_ID_flush, bus.ID_EX_flush,
              bus.EX_MEM_flush, bus.div_ready, bus.mul_ready, bus.busy};
   endfunction

   task automatic clear_inputs();
      bus.IF_ID_rs1     = 5'd0;
      bus.IF_ID_rs2     = 5'd0;
      bus.ID_EX_rd      = 5'd0;
      bus.ID_EX_memread = 1'b0;
      bus.ID_EX_div     = 1'b0;
      bus.ID_EX_mul     = 1'b0;
      bus.branch_taken  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      Rst = 1'b0;
      clear_inputs();
      @(negedge clk);
      Rst = 1'b1;
   endtask

   task automatic test_reset();
      logic [8:0] got;
      Rst = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      // Live load-use inputs must still read as zero outputs during reset.
      bus.ID_EX_memread = 1'b1;
      bus.ID_EX_rd      = 5'd7;
      bus.IF_ID_rs1     = 5'd7;
      #1 got = outs();
      n_total++;
      if (got !== O_NONE) $display("FAIL reset_in_lu got=%b exp=%b", got, O_NONE);
      else n_pass++;
      @(negedge clk);
      clear_inputs();
      Rst = 1'b1;
      #1 got = outs();
      n_total++;
      if (got !== O_NONE) $display("FAIL reset_release got=%b exp=%b", got, O_NONE);
      else n_pass++;
   endtask

   task automatic test_load_use();
      logic [8:0] got;
      // rd matches rs2
      @(negedge clk);
      bus.ID_EX_memread = 1'b1; bus.ID_EX_rd = 5'd5; bus.IF_ID_rs1 = 5'd3; bus.IF_ID_rs2 = 5'd5;
      #1 got = outs();
      n_total++;
      if (got !== O_LU) $display("FAIL lu_rs2 got=%b exp=%b", got, O_LU);
      else n_pass++;
      // load advanced: hazard gone
      @(negedge clk);
      clear_inputs();
      #1 got = outs();
      n_total++;
      if (got !== O_NONE) $display("FAIL lu_clear got=%b exp=%b", got, O_NONE);
      else n_pass++;
      // rd matches rs1
      @(negedge clk);
      bus.ID_EX_memread = 1'b1; bus.ID_EX_rd = 5'd17; bus.IF_ID_rs1 = 5'd17; bus.IF_ID_rs2 = 5'd2;
      #1 got = outs();
      n_total++;
      if (got !== O_LU) $display("FAIL lu_rs1 got=%b exp=%b", got, O_LU);
      else n_pass++;
      // rd == x0 never stalls
      @(negedge clk);
      bus.ID_EX_memread = 1'b1; bus.ID_EX_rd = 5'd0; bus.IF_ID_rs1 = 5'd0; bus.IF_ID_rs2 = 5'd0;
      #1 got = outs();
      n_total++;
      if (got !== O_NONE) $display("FAIL lu_x0 got=%b exp=%b", got, O_NONE);
      else n_pass++;
      // not a load
      @(negedge clk);
      bus.ID_EX_memread = 1'b0; bus.ID_EX_rd = 5'd9; bus.IF_ID_rs1 = 5'd9;
      #1 got = outs();
      n_total++;
      if (got !== O_NONE) $display("FAIL lu_noload got=%b exp=%b", got, O_NONE);
      else n_pass++;
      @(negedge clk);
      clear_inputs();
   endtask

   // Runs one DIV (optionally with mul also set); DIVC-1 hold cycles, release, ready.
   task automatic run_div(input string name, input logic with_mul);
      logic [8:0] got;
      logic [8:0] exp;
      for (int k = 1; k <= DIVC + 2; k++) begin
         @(negedge clk);
         if (k <= DIVC) begin
            bus.ID_EX_div = 1'b1;
            bus.ID_EX_mul = with_mul;
         end else begin
            bus.ID_EX_div = 1'b0;
            bus.ID_EX_mul = 1'b0;
         end
         if (k == 1)              exp = O_HOLD0;
         else if (k < DIVC)       exp = O_HOLD;
         else if (k == DIVC)      exp = O_REL;
         else if (k == DIVC + 1)  exp = O_DR;
         else                     exp = O_NONE;
         #1 got = outs();
         n_total++;
         if (got !== exp) $display("FAIL %s cyc=%0d got=%b exp=%b", name, k, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_div();
      run_div("div", 1'b0);
   endtask

   task automatic test_back_to_back_mul();
      logic [8:0] got;
      logic [8:0] exp;
      // Two MULs: second enters EX at the first one's release edge.
      for (int k = 1; k <= 2 * MULC + 2; k++) begin
         @(negedge clk);
         bus.ID_EX_mul = (k <= 2 * MULC);
         case (k)
            1:           exp = O_HOLD0;
            2, 3:        exp = O_HOLD;
            4:           exp = O_REL;
            5:           exp = O_MR_ST;
            6, 7:        exp = O_HOLD;
            8:           exp = O_REL;
            9:           exp = O_MR;
            default:     exp = O_NONE;
         endcase
         #1 got = outs();
         n_total++;
         if (got !== exp) $display("FAIL mul_b2b cyc=%0d got=%b exp=%b", k, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_branch();
      logic [8:0] got;
      // branch alone
      @(negedge clk);
      bus.branch_taken = 1'b1;
      #1 got = outs();
      n_total++;
      if (got !== O_BR) $display("FAIL br_only got=%b exp=%b", got, O_BR);
      else n_pass++;
      // branch with load-use: flush only
      @(negedge clk);
      bus.ID_EX_memread = 1'b1; bus.ID_EX_rd = 5'd5; bus.IF_ID_rs2 = 5'd5;
      #1 got = outs();
      n_total++;
      if (got !== O_BR) $display("FAIL br_lu got=%b exp=%b", got, O_BR);
      else n_pass++;
      // branch with DIV decode: EX hold wins
      @(negedge clk);
      clear_inputs();
      bus.branch_taken = 1'b1; bus.ID_EX_div = 1'b1;
      #1 got = outs();
      n_total++;
      if (got !== O_HOLD0) $display("FAIL br_div got=%b exp=%b", got, O_HOLD0);
      else n_pass++;
      do_reset();
   endtask

   task automatic test_reset_mid_div();
      logic [8:0] got;
      logic [8:0] exp;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         bus.ID_EX_div = 1'b1;
         exp = (k == 1) ? O_HOLD0 : O_HOLD;
         #1 got = outs();
         n_total++;
         if (got !== exp) $display("FAIL rstmid_pre cyc=%0d got=%b exp=%b", k, got, exp);
         else n_pass++;
      end
      @(negedge clk);
      Rst = 1'b0;
      #1 got = outs();
      n_total++;
      if (got !== O_NONE) $display("FAIL rstmid_low got=%b exp=%b", got, O_NONE);
      else n_pass++;
      @(negedge clk);
      clear_inputs();
      Rst = 1'b1;
      for (int k = 0; k < DIVC + 8; k++) begin
         #1 got = outs();
         n_total++;
         if (got !== O_NONE) $display("FAIL rstmid_after cyc=%0d got=%b exp=%b", k, got, O_NONE);
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_div_mul_both();
      run_div("div_mul_both", 1'b1);
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_div();
      test_back_to_back_mul();
      test_branch();
      test_reset_mid_div();
      test_div_mul_both();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
